io_handshake_unit: RTL
======================

Name: io_handshake_unit

Overview:
- Port-I/O engine that sits directly upstream of the clock divisor and drives its IOSTATE input.
- The control unit issues an I/O request and, in the same instruction, raises CUCPAUSE. The divisor then toggles its internal pause bit and freezes all CYCLEX/Y/Z phases.
- This block runs a four-phase req/ack transfer with an external device. On completion it toggles o_IOSTATE, which re-aligns with the divisor's pause bit and restarts the phase sequence.

Parameters:
- DATA_WIDTH, 16, width of the read and write data words.
- ADDR_WIDTH, 8, width of the I/O port address.
- TIMEOUT, 255, maximum cycles spent waiting in either handshake phase; must be at least 1.

Ports:
- i_CLOCK  input  1  system clock; all logic is on posedge.
- i_RESET  input  1  asynchronous, active-high reset.
- i_START  input  1  one-cycle request strobe from the control unit.
- i_WRITE  input  1  transfer direction: 1 = write, 0 = read; sampled with i_START.
- i_ADDR  input  ADDR_WIDTH  port address; sampled with i_START.
- i_WDATA  input  DATA_WIDTH  write data; sampled with i_START.
- i_CLEAR  input  1  clears the sticky error flags.
- o_IOSTATE  output  1  toggle-on-completion level; goes to the divisor's i_IOSTATE.
- o_RDATA  output  DATA_WIDTH  last read result; held until the next read completes.
- o_BUSY  output  1  high whenever the FSM is not in IDLE.
- o_TIMEOUT  output  1  sticky flag: a handshake phase timed out.
- o_OVERRUN  output  1  sticky flag: i_START arrived while busy.
- o_IO_REQ  output  1  device request.
- o_IO_WE  output  1  device write enable; valid while o_IO_REQ is high.
- o_IO_ADDR  output  ADDR_WIDTH  device address (latched copy of i_ADDR).
- o_IO_WDATA  output  DATA_WIDTH  device write data (latched copy of i_WDATA).
- i_IO_ACK  input  1  device acknowledge; treated as synchronous to i_CLOCK.
- i_IO_RDATA  input  DATA_WIDTH  device read data; valid while i_IO_ACK is high.

Behaviour:
- Reset (asynchronous):
  - Every output is 0, including o_IOSTATE = 0, which matches the divisor's initial pause = 0.
  - The FSM goes to IDLE and the timeout counter goes to 0.
- FSM states: IDLE, REQ, RELEASE, DONE. All are registered; outputs are decoded from registers only.
- IDLE:
  - On i_START, latch i_WRITE, i_ADDR and i_WDATA into the o_IO_* registers and go to REQ.
  - o_IO_REQ rises at that same edge, so the latency from start to request is 1 cycle.
- REQ:
  - o_IO_REQ = 1 and o_IO_WE = the latched write bit.
  - When i_IO_ACK is sampled high: for a read, capture i_IO_RDATA into o_RDATA; go to RELEASE and drop o_IO_REQ at that edge.
  - If the counter reaches TIMEOUT with no ack: set o_TIMEOUT, load o_RDATA with all ones if the transfer is a read, drop o_IO_REQ, and go to RELEASE.
- RELEASE:
  - o_IO_REQ = 0.
  - When i_IO_ACK is sampled low, go to DONE.
  - If the counter reaches TIMEOUT, set o_TIMEOUT and go to DONE anyway.
- DONE:
  - Lasts exactly one cycle: toggle o_IOSTATE, then go to IDLE.
  - o_BUSY falls at the same edge o_IOSTATE toggles.
- Timeout counter:
  - Cleared on every state entry; increments each cycle spent in REQ or RELEASE.
  - Wide enough to hold TIMEOUT without wrapping.
- o_IO_WE is low whenever o_IO_REQ is low.
- o_IO_ADDR and o_IO_WDATA are held stable from REQ entry until the next i_START accepted in IDLE.
- i_START while o_BUSY is high (including in DONE): the request is ignored, o_OVERRUN is set, and no latched field changes.
- i_CLEAR clears o_TIMEOUT and o_OVERRUN, but an error set in the same cycle has priority over the clear.
- o_IOSTATE toggles exactly once per accepted i_START, including transfers that time out. This guarantees the divisor never deadlocks.
- Write transfers never modify o_RDATA.
- Reset mid-transfer: o_IO_REQ drops immediately and o_IOSTATE returns to 0. The system-level reset must reset the divisor and the control unit together with this block.

Test Plan:
- Read, device acks 1 cycle after req, i_IO_RDATA = 16'hBEEF:
  - required response: o_IO_REQ high 2 cycles, o_RDATA = 16'hBEEF, o_IOSTATE 0->1, o_BUSY high 4 cycles, no flags.
- Write to addr 8'h3C with data 16'h1234, ack held 3 cycles:
  - required response: o_IO_WE = 1 and o_IO_ADDR = 8'h3C throughout req, o_RDATA unchanged, o_IOSTATE toggles once after ack falls.
- TIMEOUT = 4, read with ack never asserted:
  - required response: o_TIMEOUT set after 4 REQ cycles, o_RDATA = 16'hFFFF, o_IOSTATE still toggles, FSM back in IDLE.
- Ack stuck high after req drops, TIMEOUT = 4:
  - required response: o_TIMEOUT set, DONE reached, o_IOSTATE toggles.
- i_START pulsed during REQ with a different address:
  - required response: o_OVERRUN = 1, o_IO_ADDR unchanged, exactly one o_IOSTATE toggle.
  - then i_CLEAR clears the flag.
- i_RESET asserted mid-REQ (asynchronously, between edges):
  - required response: o_IO_REQ, o_IOSTATE and o_BUSY go to 0 without waiting for a clock edge.
  - the next i_START after reset release completes normally.

Source files
------------

// File: rtl/io_handshake_unit_if.sv
// Device-side bus of the port-I/O engine: a four-phase req/ack handshake
// carrying a latched address, write data, direction and the read return word.
interface io_handshake_unit_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  o_IO_REQ;
    logic                  o_IO_WE;
    logic [ADDR_WIDTH-1:0] o_IO_ADDR;
    logic [DATA_WIDTH-1:0] o_IO_WDATA;
    logic                  i_IO_ACK;
    logic [DATA_WIDTH-1:0] i_IO_RDATA;

    // Engine side.
    modport master (
        output o_IO_REQ,
        output o_IO_WE,
        output o_IO_ADDR,
        output o_IO_WDATA,
        input  i_IO_ACK,
        input  i_IO_RDATA
    );

    // Device side.
    modport slave (
        input  o_IO_REQ,
        input  o_IO_WE,
        input  o_IO_ADDR,
        input  o_IO_WDATA,
        output i_IO_ACK,
        output i_IO_RDATA
    );
endinterface

// File: rtl/io_handshake_unit.sv
// Port-I/O engine: runs one four-phase transfer per accepted start strobe and
// toggles o_IOSTATE on completion so the clock divisor can leave its pause.
module io_handshake_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  i_CLOCK,
    input  logic                  i_RESET,
    input  logic                  i_START,
    input  logic                  i_WRITE,
    input  logic [ADDR_WIDTH-1:0] i_ADDR,
    input  logic [DATA_WIDTH-1:0] i_WDATA,
    input  logic                  i_CLEAR,
    output logic                  o_IOSTATE,
    output logic [DATA_WIDTH-1:0] o_RDATA,
    output logic                  o_BUSY,
    output logic                  o_TIMEOUT,
    output logic                  o_OVERRUN,
    io_handshake_unit_if.master   dev
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StRelease = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  iostate_q, iostate_d;
    logic                  timeout_q, timeout_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_set;
    logic                  overrun_set;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        iostate_d   = iostate_q;
        timeout_set = 1'b0;
        overrun_set = i_START && (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (i_START) begin
                    we_d    = i_WRITE;
                    addr_d  = i_ADDR;
                    wdata_d = i_WDATA;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (dev.i_IO_ACK) begin
                    if (!we_q) begin
                        rdata_d = dev.i_IO_RDATA;
                    end
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRelease;
                end else if (cnt_q == CntLast) begin
                    // A dead device still returns a recognisable all-ones read.
                    timeout_set = 1'b1;
                    if (!we_q) begin
                        rdata_d = '1;
                    end
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRelease: begin
                if (!dev.i_IO_ACK) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    timeout_set = 1'b1;
                    cnt_d       = '0;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                iostate_d = ~iostate_q;
                cnt_d     = '0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Setting an error wins over a simultaneous clear.
        timeout_d = (timeout_q && !i_CLEAR) || timeout_set;
        overrun_d = (overrun_q && !i_CLEAR) || overrun_set;
    end

    always_ff @(posedge i_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            iostate_q <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            iostate_q <= iostate_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign dev.o_IO_REQ   = req_q;
    assign dev.o_IO_WE    = req_q && we_q;
    assign dev.o_IO_ADDR  = addr_q;
    assign dev.o_IO_WDATA = wdata_q;
    assign o_IOSTATE      = iostate_q;
    assign o_RDATA        = rdata_q;
    assign o_BUSY         = (state_q != StIdle);
    assign o_TIMEOUT      = timeout_q;
    assign o_OVERRUN      = overrun_q;
endmodule
